// File: rtl/branch_predictor_pkg.sv
// Shared pipeline definitions for the bimodal branch predictor.
package branch_predictor_pkg;

  localparam int unsigned DEFAULT_INDEX_BITS = 6;
  localparam int unsigned DEFAULT_CNT_WIDTH  = 32;

  // 2-bit saturating counter states; bit 1 is the taken prediction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_state_e;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup / execute-update bundle between the pipeline and the predictor.
interface branch_predictor_if #(
  parameter int unsigned CNT_WIDTH = 32
);
  logic [31:0]          lookup_pc;
  logic                 prediction;
  logic                 update_en;
  logic [31:0]          update_pc;
  logic                 update_taken;
  logic                 update_predicted;
  logic                 mispredicted;
  logic [CNT_WIDTH-1:0] branch_count;
  logic [CNT_WIDTH-1:0] mispredict_count;

  // Pipeline side
  modport master (
    output lookup_pc, update_en, update_pc, update_taken, update_predicted,
    input  prediction, mispredicted, branch_count, mispredict_count
  );

  // Predictor side
  modport slave (
    input  lookup_pc, update_en, update_pc, update_taken, update_predicted,
    output prediction, mispredicted, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating up/down counter step (purely combinational).
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  cnt_state_e cnt_i,
  input  logic       up_i,
  output cnt_state_e cnt_o
);

  // Step one state toward taken or not-taken, holding at the ends.
  always_comb begin
    cnt_o = cnt_i;
    unique case (cnt_i)
      SNT: cnt_o = up_i ? WNT : SNT;
      WNT: cnt_o = up_i ? WT  : SNT;
      WT:  cnt_o = up_i ? ST  : WNT;
      ST:  cnt_o = up_i ? ST  : WT;
      default: cnt_o = cnt_i;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: PC-indexed table of 2-bit counters plus statistics.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned INDEX_BITS = DEFAULT_INDEX_BITS,
  parameter int unsigned CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  branch_predictor_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** INDEX_BITS;

  logic [INDEX_BITS-1:0] lookup_idx;
  logic [INDEX_BITS-1:0] update_idx;
  cnt_state_e            pht_q [DEPTH];
  cnt_state_e            upd_cur;
  cnt_state_e            upd_next;

  logic                  mispredicted_q, mispredicted_d;
  logic [CNT_WIDTH-1:0]  branch_count_q, branch_count_d;
  logic [CNT_WIDTH-1:0]  mispredict_count_q, mispredict_count_d;

  logic                  unused_pc_bits;

  // PC word-index extraction; byte offset and high bits alias onto one entry.
  always_comb begin
    lookup_idx = bus.lookup_pc[INDEX_BITS+1:2];
    update_idx = bus.update_pc[INDEX_BITS+1:2];
    upd_cur    = pht_q[update_idx];
  end

  assign unused_pc_bits = ^{bus.lookup_pc[31:INDEX_BITS+2], bus.lookup_pc[1:0],
                            bus.update_pc[31:INDEX_BITS+2], bus.update_pc[1:0]};

  sat_counter2 u_sat (
    .cnt_i (upd_cur),
    .up_i  (bus.update_taken),
    .cnt_o (upd_next)
  );

  // Next-state for misprediction flag and statistics counters.
  always_comb begin
    mispredicted_d     = bus.update_en & (bus.update_taken ^ bus.update_predicted);
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (bus.update_en) begin
      branch_count_d = branch_count_q + CNT_WIDTH'(1);
    end
    if (mispredicted_d) begin
      mispredict_count_d = mispredict_count_q + CNT_WIDTH'(1);
    end
  end

  // Table and statistics registers; reset wins over a concurrent update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pht_q[i] <= WNT;
      end
      mispredicted_q     <= 1'b0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      if (bus.update_en) begin
        pht_q[update_idx] <= upd_next;
      end
      mispredicted_q     <= mispredicted_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  // Lookup reads the pre-update state: no bypass from the update port.
  assign bus.prediction       = pht_q[lookup_idx][1];
  assign bus.mispredicted     = mispredicted_q;
  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;

endmodule
